// File: rtl/is_tile_sequencer.sv
// Sequences one input-stationary tile: vertical activation load, weight streaming,
// drain, with a single-cycle transient fault mask and a log strobe for the array pair.
module is_tile_sequencer #(
  parameter int D_W       = 8,
  parameter int N         = 8,
  parameter int STEP_W    = 16,
  parameter int DRAIN_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [STEP_W-1:0]         num_steps,
  output logic                      act_rd_en,
  output logic [$clog2(N)-1:0]      act_rd_addr,
  input  logic [N*D_W-1:0]          act_rd_data,
  output logic                      w_rd_en,
  output logic [STEP_W-1:0]         w_rd_addr,
  input  logic [N*D_W-1:0]          w_rd_data,
  output logic                      load_weight,
  output logic [N*D_W-1:0]          m1_flat,
  output logic [N*D_W-1:0]          m0_flat,
  input  logic                      fault_en,
  input  logic [$clog2(N)-1:0]      fault_row,
  input  logic [$clog2(N)-1:0]      fault_col,
  input  logic [STEP_W:0]           fault_cycle,
  input  logic [D_W-1:0]            fault_val,
  output logic [N*N*D_W-1:0]        fault_mask_flat,
  output logic                      log_en,
  output logic [STEP_W:0]           cyc,
  output logic                      busy,
  output logic                      done
);

  localparam int AW    = $clog2(N);
  localparam int ROW_W = N * D_W;
  localparam int MSK_W = N * N * D_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [STEP_W-1:0] num_steps;
    logic              fault_en;
    logic [AW-1:0]     fault_row;
    logic [AW-1:0]     fault_col;
    logic [STEP_W:0]   fault_cycle;
    logic [D_W-1:0]    fault_val;
  } cfg_t;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  cfg_t              cfg_q, cfg_d;

  // Read-return pipeline: a strobe issued this cycle has its data on the bus next cycle.
  logic              act_vld_q, act_vld_d;
  logic              w_vld_q, w_vld_d;
  logic              post_q, post_d;

  logic              load_weight_q, load_weight_d;
  logic [ROW_W-1:0]  m1_q, m1_d;
  logic [ROW_W-1:0]  m0_q, m0_d;
  logic [MSK_W-1:0]  mask_q, mask_d;
  logic              log_en_q, log_en_d;
  logic [STEP_W:0]   cyc_q, cyc_d;

  logic [STEP_W:0]   last_cyc;
  logic              flush;
  logic              fault_hit;
  int                fault_idx;

  assign last_cyc = {1'b0, cfg_q.num_steps} + (STEP_W+1)'(DRAIN_CYC) - (STEP_W+1)'(1);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin : ctrl_next
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d = '{num_steps:   num_steps,
                    fault_en:    fault_en,
                    fault_row:   fault_row,
                    fault_col:   fault_col,
                    fault_cycle: fault_cycle,
                    fault_val:   fault_val};
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == STEP_W'(N-1)) begin
          cnt_d   = '0;
          state_d = (cfg_q.num_steps == '0) ? S_DRAIN : S_COMPUTE;
        end else begin
          cnt_d = cnt_q + STEP_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt_q == cfg_q.num_steps - STEP_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + STEP_W'(1);
        end
      end
      // Drain holds until the log window (delayed two cycles by the read pipeline) closes.
      S_DRAIN: begin
        if (log_en_q && cyc_q == last_cyc) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin : datapath_next
    flush     = (state_d == S_IDLE) || (state_d == S_DONE);
    act_vld_d = !flush && (state_q == S_LOAD);
    w_vld_d   = !flush && (state_q == S_COMPUTE);
    post_d    = !flush && ((state_q == S_COMPUTE) || (state_q == S_DRAIN));

    load_weight_d = !flush && act_vld_q;
    m1_d          = (!flush && act_vld_q) ? act_rd_data : '0;
    m0_d          = (!flush && w_vld_q)   ? w_rd_data   : '0;

    log_en_d = 1'b0;
    if (!flush) log_en_d = log_en_q ? (cyc_q != last_cyc) : post_q;
    cyc_d = '0;
    if (log_en_d) cyc_d = log_en_q ? cyc_q + (STEP_W+1)'(1) : '0;

    fault_idx = int'(cfg_q.fault_row) * N + int'(cfg_q.fault_col);
    fault_hit = cfg_q.fault_en && log_en_d && (cyc_d == cfg_q.fault_cycle);
    mask_d    = '0;
    for (int i = 0; i < N*N; i++) begin
      if (fault_hit && i == fault_idx) mask_d[i*D_W +: D_W] = cfg_q.fault_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cfg_q         <= '0;
      act_vld_q     <= 1'b0;
      w_vld_q       <= 1'b0;
      post_q        <= 1'b0;
      load_weight_q <= 1'b0;
      m1_q          <= '0;
      m0_q          <= '0;
      mask_q        <= '0;
      log_en_q      <= 1'b0;
      cyc_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_q         <= cfg_d;
      act_vld_q     <= act_vld_d;
      w_vld_q       <= w_vld_d;
      post_q        <= post_d;
      load_weight_q <= load_weight_d;
      m1_q          <= m1_d;
      m0_q          <= m0_d;
      mask_q        <= mask_d;
      log_en_q      <= log_en_d;
      cyc_q         <= cyc_d;
    end
  end

  // Activation rows are fetched bottom-up so row N-1 enters the array first.
  assign act_rd_en       = (state_q == S_LOAD);
  assign act_rd_addr     = act_rd_en ? (AW'(N-1) - cnt_q[AW-1:0]) : '0;
  assign w_rd_en         = (state_q == S_COMPUTE);
  assign w_rd_addr       = w_rd_en ? cnt_q : '0;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign load_weight     = load_weight_q;
  assign m1_flat         = m1_q;
  assign m0_flat         = m0_q;
  assign fault_mask_flat = mask_q;
  assign log_en          = log_en_q;
  assign cyc             = cyc_q;

endmodule

// File: tb/tb_is_tile_sequencer.sv
// Bench for is_tile_sequencer: a timeline model derived from tile start checks every
// output on every cycle, plus literal expectations for the directed tiles.
module tb_is_tile_sequencer;

  localparam int N         = 4;
  localparam int D_W       = 8;
  localparam int STEP_W    = 16;
  localparam int DRAIN_CYC = 4;
  localparam int AW        = $clog2(N);
  localparam int ROW_W     = N * D_W;
  localparam int MASK_W    = N * N * D_W;
  localparam int W_DEPTH   = 64;
  localparam int WA        = $clog2(W_DEPTH);

  logic                clk;
  logic                rst;
  logic                start;
  logic                abort;
  logic [STEP_W-1:0]   num_steps;
  logic                act_rd_en;
  logic [AW-1:0]       act_rd_addr;
  logic [ROW_W-1:0]    act_rd_data;
  logic                w_rd_en;
  logic [STEP_W-1:0]   w_rd_addr;
  logic [ROW_W-1:0]    w_rd_data;
  logic                load_weight;
  logic [ROW_W-1:0]    m1_flat;
  logic [ROW_W-1:0]    m0_flat;
  logic                fault_en;
  logic [AW-1:0]       fault_row;
  logic [AW-1:0]       fault_col;
  logic [STEP_W:0]     fault_cycle;
  logic [D_W-1:0]      fault_val;
  logic [MASK_W-1:0]   fault_mask_flat;
  logic                log_en;
  logic [STEP_W:0]     cyc;
  logic                busy;
  logic                done;

  is_tile_sequencer #(
    .D_W(D_W), .N(N), .STEP_W(STEP_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .load_weight(load_weight), .m1_flat(m1_flat), .m0_flat(m0_flat),
    .fault_en(fault_en), .fault_row(fault_row), .fault_col(fault_col),
    .fault_cycle(fault_cycle), .fault_val(fault_val), .fault_mask_flat(fault_mask_flat),
    .log_en(log_en), .cyc(cyc), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ROW_W-1:0] act_mem [N];
  logic [ROW_W-1:0] w_mem [W_DEPTH];

  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < N; i++) r[i*D_W +: D_W] = D_W'($urandom);
    return r;
  endfunction

  // Memories answer one cycle after the strobe; idle cycles carry garbage.
  always @(posedge clk) begin
    act_rd_data <= act_rd_en ? act_mem[act_rd_addr] : rnd_row();
    w_rd_data   <= w_rd_en ? w_mem[w_rd_addr[WA-1:0]] : rnd_row();
  end

  // Model: only whether a tile is running, the cycle offset since start, and the latched config.
  logic           m_active = 1'b0;
  int             m_rel = 0;
  int             m_s = 0;
  logic           m_fen = 1'b0;
  int             m_frow = 0;
  int             m_fcol = 0;
  int             m_fcyc = 0;
  logic [D_W-1:0] m_fval = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (abort || m_rel == N + 3 + m_s + DRAIN_CYC) m_active <= 1'b0;
      else m_rel <= m_rel + 1;
    end else if (start) begin
      m_active <= 1'b1;
      m_rel    <= 1;
      m_s      <= int'(num_steps);
      m_fen    <= fault_en;
      m_frow   <= int'(fault_row);
      m_fcol   <= int'(fault_col);
      m_fcyc   <= int'(fault_cycle);
      m_fval   <= fault_val;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [MASK_W-1:0] act, input logic [MASK_W-1:0] exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-tile observations of the DUT, compared later against literal expectations.
  int lw_cnt = 0, log_cnt = 0, done_cnt = 0, w_en_cnt = 0, m0_nz = 0, mask_hits = 0;
  logic [MASK_W-1:0] mask_last = '0;
  int                mask_cyc_last = -1;
  logic [ROW_W-1:0]  m1_log [$];

  task automatic compare_cycle();
    int               rel;
    int               i;
    logic             e_act_en, e_lw, e_w_en, e_log, e_done;
    logic [AW-1:0]    e_act_addr;
    logic [STEP_W-1:0] e_w_addr;
    logic [ROW_W-1:0] e_m1, e_m0;
    logic [STEP_W:0]  e_cyc;
    logic [MASK_W-1:0] e_mask;
    rel        = m_rel;
    i          = rel - N - 3;
    e_act_en   = m_active && rel >= 1 && rel <= N;
    e_act_addr = e_act_en ? AW'(N - rel) : '0;
    e_lw       = m_active && rel >= 3 && rel <= N + 2;
    e_m1       = '0;
    if (e_lw) e_m1 = act_mem[N + 2 - rel];
    e_w_en     = m_active && rel >= N + 1 && rel <= N + m_s;
    e_w_addr   = e_w_en ? STEP_W'(rel - N - 1) : '0;
    e_log      = m_active && rel >= N + 3 && rel <= N + 2 + m_s + DRAIN_CYC;
    e_cyc      = e_log ? (STEP_W+1)'(i) : '0;
    e_m0       = '0;
    if (e_log && i < m_s) e_m0 = w_mem[i % W_DEPTH];
    e_mask     = '0;
    if (e_log && m_fen && i == m_fcyc) e_mask[(m_frow*N + m_fcol)*D_W +: D_W] = m_fval;
    e_done     = m_active && rel == N + 3 + m_s + DRAIN_CYC;

    check("busy",        MASK_W'(busy),            MASK_W'(m_active));
    check("done",        MASK_W'(done),            MASK_W'(e_done));
    check("act_rd_en",   MASK_W'(act_rd_en),       MASK_W'(e_act_en));
    check("act_rd_addr", MASK_W'(act_rd_addr),     MASK_W'(e_act_addr));
    check("load_weight", MASK_W'(load_weight),     MASK_W'(e_lw));
    check("m1_flat",     MASK_W'(m1_flat),         MASK_W'(e_m1));
    check("w_rd_en",     MASK_W'(w_rd_en),         MASK_W'(e_w_en));
    check("w_rd_addr",   MASK_W'(w_rd_addr),       MASK_W'(e_w_addr));
    check("log_en",      MASK_W'(log_en),          MASK_W'(e_log));
    check("cyc",         MASK_W'(cyc),             MASK_W'(e_cyc));
    check("m0_flat",     MASK_W'(m0_flat),         MASK_W'(e_m0));
    check("fault_mask",  fault_mask_flat,          e_mask);
  endtask

  task automatic observe();
    if (load_weight) begin
      lw_cnt++;
      m1_log.push_back(m1_flat);
    end
    if (log_en) log_cnt++;
    if (log_en && m0_flat != '0) m0_nz++;
    if (done) done_cnt++;
    if (w_rd_en) w_en_cnt++;
    if (fault_mask_flat != '0) begin
      mask_hits++;
      mask_last     = fault_mask_flat;
      mask_cyc_last = int'(cyc);
    end
  endtask

  typedef struct {
    int lw, log_c, done_c, w_en, m0n, mhits, m1_base;
  } snap_t;

  function automatic snap_t snap();
    snap_t s;
    s.lw = lw_cnt; s.log_c = log_cnt; s.done_c = done_cnt; s.w_en = w_en_cnt;
    s.m0n = m0_nz; s.mhits = mask_hits; s.m1_base = m1_log.size();
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle, then scrambles the config inputs to prove they were latched.
  task automatic launch(input int s, input logic fen, input int frow, input int fcol,
                        input int fcyc, input int fval);
    num_steps   = STEP_W'(s);
    fault_en    = fen;
    fault_row   = AW'(frow);
    fault_col   = AW'(fcol);
    fault_cycle = (STEP_W+1)'(fcyc);
    fault_val   = D_W'(fval);
    start       = 1'b1;
    tick();
    start       = 1'b0;
    num_steps   = STEP_W'($urandom);
    fault_en    = 1'($urandom);
    fault_row   = AW'($urandom);
    fault_col   = AW'($urandom);
    fault_cycle = (STEP_W+1)'($urandom);
    fault_val   = D_W'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, MASK_W'(busy), '0);
  endtask

  task automatic wait_for_w_rd(input string name, input int budget);
    int n;
    n = 0;
    while (!w_rd_en && n < budget) begin
      tick();
      n++;
    end
    check(name, MASK_W'(w_rd_en), MASK_W'(1));
  endtask

  initial begin
    snap_t s0;
    int    n;
    int    s;
    logic  do_abort;
    int    abort_at;

    rst = 1'b1; start = 1'b0; abort = 1'b0; num_steps = '0; fault_en = 1'b0;
    fault_row = '0; fault_col = '0; fault_cycle = '0; fault_val = '0;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
        observe();
      end
    join_none

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) act_mem[r][c*D_W +: D_W] = D_W'(r * 8'h11);
    for (int w = 0; w < W_DEPTH; w++)
      for (int c = 0; c < N; c++) w_mem[w][c*D_W +: D_W] = D_W'(8'hA0 + w);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy",  MASK_W'(busy), '0);
    check("reset_m1",    MASK_W'(m1_flat), '0);
    check("reset_mask",  fault_mask_flat, '0);
    tick();

    // Plain tile: 3 steps, no fault.
    s0 = snap();
    launch(3, 1'b0, 0, 0, 0, 0);
    wait_idle("tileA_idle", 60);
    check("tileA_lw_cycles", MASK_W'(lw_cnt - s0.lw), MASK_W'(4));
    check("tileA_m1_row3",   MASK_W'(m1_log[s0.m1_base + 0]), MASK_W'(32'h33333333));
    check("tileA_m1_row2",   MASK_W'(m1_log[s0.m1_base + 1]), MASK_W'(32'h22222222));
    check("tileA_m1_row1",   MASK_W'(m1_log[s0.m1_base + 2]), MASK_W'(32'h11111111));
    check("tileA_m1_row0",   MASK_W'(m1_log[s0.m1_base + 3]), MASK_W'(32'h00000000));
    check("tileA_log_cycles", MASK_W'(log_cnt - s0.log_c), MASK_W'(7));
    check("tileA_m0_nonzero", MASK_W'(m0_nz - s0.m0n), MASK_W'(3));
    check("tileA_w_reads",   MASK_W'(w_en_cnt - s0.w_en), MASK_W'(3));
    check("tileA_done",      MASK_W'(done_cnt - s0.done_c), MASK_W'(1));
    check("tileA_no_mask",   MASK_W'(mask_hits - s0.mhits), '0);
    tick();

    // Same tile with a fault on PE[2][1] at compute cycle 1.
    s0 = snap();
    launch(3, 1'b1, 2, 1, 1, 8'h80);
    wait_idle("fault_idle", 60);
    check("fault_hits",  MASK_W'(mask_hits - s0.mhits), MASK_W'(1));
    check("fault_value", mask_last, MASK_W'(128'h80) << 72);
    check("fault_cyc",   MASK_W'(mask_cyc_last), MASK_W'(1));
    tick();

    // Zero weight steps: load, then a pure drain window.
    s0 = snap();
    launch(0, 1'b0, 0, 0, 0, 0);
    wait_idle("zero_idle", 60);
    check("zero_lw_cycles",  MASK_W'(lw_cnt - s0.lw), MASK_W'(4));
    check("zero_log_cycles", MASK_W'(log_cnt - s0.log_c), MASK_W'(DRAIN_CYC));
    check("zero_w_reads",    MASK_W'(w_en_cnt - s0.w_en), '0);
    check("zero_m0",         MASK_W'(m0_nz - s0.m0n), '0);
    check("zero_done",       MASK_W'(done_cnt - s0.done_c), MASK_W'(1));
    tick();

    // Start pulsed during COMPUTE and during the DONE cycle.
    s0 = snap();
    launch(3, 1'b0, 0, 0, 0, 0);
    wait_for_w_rd("restart_compute_seen", 20);
    num_steps = STEP_W'(9);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("restart_done_seen", MASK_W'(done), MASK_W'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_idle_after_done", MASK_W'(busy), '0);
    tick();
    check("restart_still_idle", MASK_W'(busy), '0);
    check("restart_w_reads", MASK_W'(w_en_cnt - s0.w_en), MASK_W'(3));
    check("restart_done",    MASK_W'(done_cnt - s0.done_c), MASK_W'(1));

    // Abort in LOAD cycle 2, then reset mid-COMPUTE of a second tile.
    s0 = snap();
    launch(3, 1'b0, 0, 0, 0, 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", MASK_W'(busy), '0);
    check("abort_lw",   MASK_W'(load_weight), '0);
    check("abort_m1",   MASK_W'(m1_flat), '0);
    tick();
    launch(5, 1'b1, 1, 3, 2, 8'h5A);
    wait_for_w_rd("rst_compute_seen", 20);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_busy",   MASK_W'(busy), '0);
    check("rst_m0",     MASK_W'(m0_flat), '0);
    check("rst_log_en", MASK_W'(log_en), '0);
    check("rst_w_rd",   MASK_W'(w_rd_en), '0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_rst_no_done", MASK_W'(done_cnt - s0.done_c), '0);
    s0 = snap();
    launch(3, 1'b0, 0, 0, 0, 0);
    wait_idle("third_idle", 60);
    check("third_log_cycles", MASK_W'(log_cnt - s0.log_c), MASK_W'(7));
    check("third_lw_cycles",  MASK_W'(lw_cnt - s0.lw), MASK_W'(4));
    check("third_done",       MASK_W'(done_cnt - s0.done_c), MASK_W'(1));
    tick();

    // Fault cycle just past the log window never fires.
    s0 = snap();
    launch(3, 1'b1, 3, 3, 3 + DRAIN_CYC, 8'hFF);
    wait_idle("oow_idle", 60);
    check("oow_no_mask", MASK_W'(mask_hits - s0.mhits), '0);
    tick();

    // Randomized tiles with stray start pulses, input churn and occasional aborts.
    for (int t = 0; t < 25; t++) begin
      for (int r = 0; r < N; r++) act_mem[r] = rnd_row();
      for (int w = 0; w < W_DEPTH; w++) w_mem[w] = rnd_row();
      s = $urandom_range(0, 12);
      do_abort = ($urandom_range(0, 4) == 0);
      abort_at = $urandom_range(1, N + s + DRAIN_CYC + 3);
      launch(s, 1'($urandom), $urandom_range(0, N-1), $urandom_range(0, N-1),
             $urandom_range(0, s + DRAIN_CYC + 1), $urandom_range(0, 255));
      n = 0;
      while (busy && n < 200) begin
        start       = ($urandom_range(0, 3) == 0);
        abort       = do_abort && (n == abort_at);
        num_steps   = STEP_W'($urandom);
        fault_cycle = (STEP_W+1)'($urandom);
        fault_val   = D_W'($urandom);
        tick();
        n++;
      end
      start = 1'b0;
      abort = 1'b0;
      check("rand_idle", MASK_W'(busy), '0);
      tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
